imem_boot_ctrl: RTL and testbench
=================================

// Module: imem_boot_ctrl
// PURPOSE
//   Boot/load sequencer for the mips_16 instruction memory. Receives a program image as a
//   byte stream, writes it into IMEM as 16-bit words from address 0, and holds the core in
//   reset with fetch disabled. It then releases the core and asserts instruction_fetch_en.
//   Sits between the host/loader interface and the IF stage (IMEM write port, fetch enable).
// PARAMETERS
//   ADDR_W     8   IMEM word-address width (= PC_WIDTH); capacity 2**ADDR_W words
//   AUTO_BOOT  1   1: leave reset straight into header load; 0: wait in IDLE for boot_req
// PORTS
//   clk                   in   1       system clock, all logic on posedge
//   rst                   in   1       synchronous, active-high reset
//   boot_req              in   1       start/restart a load (sampled in IDLE, RUN, ERR)
//   byte_valid            in   1       loader byte available
//   byte_data             in   8       loader byte
//   byte_ready            out  1       controller accepts byte; transfer = valid & ready
//   imem_we               out  1       IMEM write strobe, one cycle per word
//   imem_waddr            out  ADDR_W  IMEM word address
//   imem_wdata            out  16      IMEM write data {hi_byte, lo_byte}
//   cpu_rst               out  1       pipeline reset, high whenever not in RUN
//   instruction_fetch_en  out  1       IF stage enable, high only in RUN
//   busy                  out  1       high in HDR_HI..FLUSH
//   err                   out  1       high in ERR
// BEHAVIOUR
//   Reset: state=IDLE (AUTO_BOOT=0) or HDR_HI (AUTO_BOOT=1), taking effect the cycle after
//     rst falls; all outputs 0 except cpu_rst=1; word counter=0. Reset mid-load aborts
//     cleanly; partial IMEM contents are don't-care.
//   Stream format: N_hi, N_lo (16-bit word count N, MSB first), then N words, hi byte first.
//   States: IDLE, HDR_HI, HDR_LO, W_HI, W_LO, [CSUM], FLUSH, RUN, ERR.
//     IDLE  : byte_ready=0; boot_req -> HDR_HI.
//     HDR_HI: byte_ready=1; on transfer latch N[15:8] -> HDR_LO.
//     HDR_LO: on transfer latch N[7:0]; N==0 -> CSUM/FLUSH; N>2**ADDR_W -> ERR; else W_HI.
//     W_HI  : on transfer latch hi byte -> W_LO.
//     W_LO  : on transfer register imem_we=1, waddr=cnt, wdata={hi,byte} (visible next
//             cycle, exactly one cycle); cnt++. Last word (cnt==N-1) -> CSUM/FLUSH, else W_HI.
//     FLUSH : one cycle, byte_ready=0, cpu_rst=1 (covers last write) -> RUN.
//     RUN   : cpu_rst=0, instruction_fetch_en=1 from the first RUN cycle; boot_req -> HDR_HI
//             (cpu_rst and fetch_en change the same cycle the state changes).
//     ERR   : err=1, cpu_rst=1; leave only via boot_req -> HDR_HI or rst.
//   byte_valid without byte_ready is ignored; stalls of any length are allowed between bytes.
//   boot_req is ignored in HDR_HI..FLUSH.
//   cnt is ADDR_W+1 bits; N==2**ADDR_W is legal and fills the memory (last waddr=all ones).
//   Load latency: RUN entered 2 cycles after the final byte transfer.
// CONFIGURATION
//   IMEM_BOOT_CHECKSUM_EN defined: CSUM state follows the last word (or HDR_LO when N==0).
//     It accepts one byte; the 8-bit sum of all stream bytes including this one must equal
//     0 (mod 256). Match -> FLUSH; mismatch -> ERR.
//   Undefined: no CSUM state and no sum register; err is set only on oversize N.
// TESTING
//   AUTO_BOOT=1, stream 00 02 12 34 AB CD -> imem_we at addr 0 =1234, addr 1 =ABCD;
//     fetch_en=1 and cpu_rst=0 2 cycles after byte CD.
//   Stream 00 00 -> no imem_we; RUN 2 cycles after 2nd byte (checksum build: 00 00 00).
//   ADDR_W=8, header 01 01 (N=257) -> err=1, fetch_en=0; boot_req + valid stream -> RUN.
//   byte_valid toggling randomly 0/1 during a 4-word load -> same writes, order, addresses.
//   rst pulsed after 3rd byte, then full stream -> clean load from addr 0, single RUN entry.
//   IMEM_BOOT_CHECKSUM_EN: 00 01 12 34 B9 -> RUN; checksum byte B8 -> ERR, err=1.

Source files
------------

// File: rtl/imem_boot_if.sv
// imem_boot_if: loader byte stream, IMEM write port and core-control bundle for imem_boot_ctrl
interface imem_boot_if #(
    parameter int ADDR_W = 8
);
    logic              boot_req;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [15:0]       imem_wdata;
    logic              cpu_rst;
    logic              instruction_fetch_en;
    logic              busy;
    logic              err;
    modport master (
        output boot_req, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, instruction_fetch_en, busy, err
    );
    modport slave (
        input  boot_req, byte_valid, byte_data,
        output byte_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, instruction_fetch_en, busy, err
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: loads a byte-stream program image into IMEM, then releases the core into fetch.
// IMEM_BOOT_CHECKSUM_EN adds a trailing checksum byte that must bring the stream sum to 0.
module imem_boot_ctrl #(
    parameter int ADDR_W    = 8,
    parameter bit AUTO_BOOT = 1'b1
) (
    input logic        clk,
    input logic        rst,
    imem_boot_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, HDR_HI, HDR_LO, W_HI, W_LO,
`ifdef IMEM_BOOT_CHECKSUM_EN
        CSUM,
`endif
        FLUSH, RUN, ERR
    } state_t;
    localparam state_t RST_STATE = AUTO_BOOT ? HDR_HI : IDLE;
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_t POST = CSUM;
`else
    localparam state_t POST = FLUSH;
`endif
    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              xfer, last_word, oversize;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d, sum_nxt;
    assign sum_nxt = sum_q + bus.byte_data;
`endif
    // Outputs are masked while rst is held so the core sees a quiet, reset-only interface.
    assign bus.busy                 = ~rst & (state_q inside {[HDR_HI:FLUSH]});
    assign bus.byte_ready           = bus.busy & (state_q != FLUSH);
    assign bus.err                  = ~rst & (state_q == ERR);
    assign bus.instruction_fetch_en = ~rst & (state_q == RUN);
    assign bus.cpu_rst              = rst | (state_q != RUN);
    assign bus.imem_we              = we_q;
    assign bus.imem_waddr           = waddr_q;
    assign bus.imem_wdata           = wdata_q;
    assign xfer      = bus.byte_valid & bus.byte_ready;
    assign oversize  = {1'b0, n_q[15:8], bus.byte_data} > (17'd1 << ADDR_W);
    assign last_word = 17'(cnt_q) + 17'd1 == {1'b0, n_q};
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_d   = xfer ? sum_nxt : sum_q;
`endif
        case (state_q)
            IDLE, RUN, ERR: state_d = bus.boot_req ? HDR_HI : state_q;
            HDR_HI: if (xfer) begin
                n_d[15:8] = bus.byte_data;
                cnt_d     = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                sum_d     = bus.byte_data;
`endif
                state_d   = HDR_LO;
            end
            HDR_LO: if (xfer) begin
                n_d[7:0] = bus.byte_data;
                state_d  = ({n_q[15:8], bus.byte_data} == 16'd0) ? POST : oversize ? ERR : W_HI;
            end
            W_HI: if (xfer) begin
                hi_d    = bus.byte_data;
                state_d = W_LO;
            end
            W_LO: if (xfer) begin
                we_d    = 1'b1;
                waddr_d = cnt_q[ADDR_W-1:0];
                wdata_d = {hi_q, bus.byte_data};
                cnt_d   = cnt_q + 1'b1;
                state_d = last_word ? POST : W_HI;
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            CSUM: if (xfer) state_d = (sum_nxt == 8'd0) ? FLUSH : ERR;
`endif
            FLUSH: state_d = RUN;
            default: state_d = RST_STATE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            n_q     <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: directed and randomized loads checked against a stream-level model of the loader
module tb_imem_boot_ctrl;
    localparam int AW  = 8;
    localparam int CAP = 1 << AW;
    typedef logic [7:0]    u8_t;
    typedef logic [AW-1:0] addr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    imem_boot_if #(.ADDR_W(AW)) bus ();
    imem_boot_ctrl #(.ADDR_W(AW), .AUTO_BOOT(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [23:0] wq[$];
    int runs = 0;
    logic fe_prev = 1'b0;
    u8_t stream[$];

    always @(posedge clk) begin
        #2;
        if (bus.imem_we) wq.push_back({bus.imem_waddr, bus.imem_wdata});
        if (bus.instruction_fetch_en && !fe_prev) runs++;
        fe_prev <= bus.instruction_fetch_en;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_csum();
`ifdef IMEM_BOOT_CHECKSUM_EN
        int s = 0;
        foreach (stream[i]) s += int'(stream[i]);
        stream.push_back(u8_t'(-s));
`endif
    endtask

    task automatic build(input int n);
        stream.delete();
        stream.push_back(u8_t'(n >> 8));
        stream.push_back(u8_t'(n));
        for (int i = 0; i < 2 * n; i++) stream.push_back(u8_t'($urandom));
        add_csum();
    endtask

    task automatic send(input u8_t b, input bit stall);
        int t = 0;
        if (stall) repeat ($urandom_range(3)) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = u8_t'($urandom);
            bus.boot_req   = 1'($urandom);
            @(negedge clk);
        end
        bus.boot_req   = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.byte_ready) begin
            total++;
            bad++;
            $error("FAIL ready_timeout: byte_ready=%b required 1", bus.byte_ready);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic boot();
        bus.boot_req = 1'b1;
        @(negedge clk);
        bus.boot_req = 1'b0;
        chk("boot_busy", bus.busy, 1);
        chk("boot_fe", bus.instruction_fetch_en, 0);
    endtask

    // Model: N from the header; N words land at addresses 0..N-1 unless N exceeds capacity
    // (or, with checksum, the byte sum of the whole stream is nonzero).
    task automatic load(input string tag, input bit stall);
        int n = int'({stream[0], stream[1]});
        int s = 0;
        int base = wq.size();
        int rb = runs;
        int nb;
        bit ok;
        logic [23:0] exp_w[$];
        foreach (stream[i]) s += int'(stream[i]);
        ok = n <= CAP;
`ifdef IMEM_BOOT_CHECKSUM_EN
        ok = ok && (s % 256 == 0);
`endif
        nb = (n > CAP) ? 2 : stream.size();
        if (n <= CAP) for (int i = 0; i < n; i++) exp_w.push_back({addr_t'(i), stream[2 + 2 * i], stream[3 + 2 * i]});
        for (int i = 0; i < nb; i++) send(stream[i], stall);
        if (!ok) begin
            chk({tag, "_err"}, bus.err, 1);
            chk({tag, "_err_fe"}, bus.instruction_fetch_en, 0);
            chk({tag, "_err_crst"}, bus.cpu_rst, 1);
        end else begin
            chk({tag, "_flush_fe"}, bus.instruction_fetch_en, 0);
            chk({tag, "_flush_busy"}, bus.busy, 1);
            @(negedge clk);
            chk({tag, "_run_fe"}, bus.instruction_fetch_en, 1);
            chk({tag, "_run_crst"}, bus.cpu_rst, 0);
            chk({tag, "_run_busy"}, bus.busy, 0);
        end
        chk({tag, "_nwr"}, wq.size() - base, exp_w.size());
        for (int i = 0; i < exp_w.size() && base + i < wq.size(); i++) chk({tag, "_wr"}, wq[base + i], exp_w[i]);
        chk({tag, "_runs"}, runs - rb, ok ? 1 : 0);
    endtask

    initial begin
        int rb0;
        int wb;
        bus.boot_req   = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.byte_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.imem_we, 0);
        chk("rst_crst", bus.cpu_rst, 1);
        chk("rst_fe", bus.instruction_fetch_en, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;
        #1;
        chk("auto_ready", bus.byte_ready, 1);
        @(negedge clk);
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        add_csum();
        load("basic", 1'b0);
        wb = wq.size();
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        repeat (3) @(negedge clk);
        chk("run_ign_ready", bus.byte_ready, 0);
        chk("run_ign_fe", bus.instruction_fetch_en, 1);
        chk("run_ign_wr", wq.size() - wb, 0);
        bus.byte_valid = 1'b0;
        boot();
        stream = '{8'h00, 8'h00};
        add_csum();
        load("empty", 1'b0);
        boot();
        stream = '{8'h01, 8'h01};
        load("over", 1'b0);
        repeat (3) @(negedge clk);
        chk("err_hold", bus.err, 1);
        boot();
        build(3);
        load("after_err", 1'b1);
        boot();
        build(4);
        load("stall4", 1'b1);
        boot();
        build(CAP);
        load("full", 1'b0);
        boot();
        build(2);
        rb0 = runs;
        for (int i = 0; i < 3; i++) send(stream[i], 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", bus.busy, 1);
        @(negedge clk);
        build(4);
        load("post_rst", 1'b1);
        chk("rst_single_run", runs - rb0, 1);
        for (int k = 0; k < 6; k++) begin
            boot();
            build(int'($urandom_range(1, 8)));
            load("rnd", 1'b1);
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        boot();
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'hB9};
        load("cs_ok", 1'b0);
        boot();
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'hB8};
        load("cs_bad", 1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
